bias_sweep_ctrl: RTL and testbench

Digital sequencer that steps the segment-enable code of the on-chip PMOS bias mirrors across a programmable range on each selected channel. At each point it waits a settle time, then handshakes with the measurement path. This is the on-silicon equivalent of the bench width/supply sweep, generalised to N channels, programmable start/stop/step, single-shot or continuous mode, and abort. It sits between the tile IO registers and the bias mirror switch banks of the folded-cascode core.

---
 rtl/bias_sweep_pkg.sv | 30 +++
 rtl/bias_dwell_cnt.sv | 30 +++
 rtl/bias_sweep_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_bias_sweep_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_sweep_pkg.sv
// Shared types and helpers for the bias mirror sweep sequencer.
package bias_sweep_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StSample,
      StStep,
      StDone
   } state_e;

   localparam int unsigned PARK_CODE_DEF = 1;
   localparam int unsigned MAX_CH        = 32;

   // Lowest set bit of mask strictly above idx; pass idx = -1 to get the lowest set bit.
   function automatic int next_set_bit(input logic [MAX_CH-1:0] mask, input int idx,
                                       output logic found);
      int res;
      res   = 0;
      found = 1'b0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (mask[i] && (i > idx)) begin
            res   = i;
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bias_dwell_cnt.sv
// Settle-time down-counter: loadable, enable-gated, saturates at zero and flags it.
module bias_dwell_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (en) begin
         if (load) begin
            cnt_q <= load_val;
         end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/bias_sweep_ctrl.sv
// Steps the PMOS mirror segment code of each selected channel across a programmable range,
// settling and handshaking with the measurement path at every point.
module bias_sweep_ctrl
   import bias_sweep_pkg::*;
#(
   parameter int unsigned CODE_W    = 4,
   parameter int unsigned N_CH      = 2,
   parameter int unsigned DWELL_W   = 8,
   parameter int unsigned PARK_CODE = PARK_CODE_DEF,
   localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     cont,
   input  logic [N_CH-1:0]          ch_mask,
   input  logic [CODE_W-1:0]        start_code,
   input  logic [CODE_W-1:0]        stop_code,
   input  logic [CODE_W-1:0]        step_code,
   input  logic [DWELL_W-1:0]       dwell,
   input  logic                     sample_ack,
   output logic [N_CH*CODE_W-1:0]   bias_code,
   output logic [CH_W-1:0]          ch_idx,
   output logic                     sample_req,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam logic [CODE_W-1:0] PARK = CODE_W'(PARK_CODE);

   state_e                 state_q;
   logic [N_CH-1:0]        mask_q;
   logic [CODE_W-1:0]      start_q, stop_q, step_q, code_q;
   logic [DWELL_W-1:0]     dwell_q;
   logic                   cont_q;
   logic [N_CH*CODE_W-1:0] bias_q;
   logic [CH_W-1:0]        ch_q;
   logic                   req_q, busy_q, done_q, err_q;

   logic                   idle_like;
   logic                   first_found, higher_found, wrap_found;
   logic [CH_W-1:0]        first_idx, higher_idx, wrap_idx;
   logic [CODE_W-1:0]      step_eff;
   logic [CODE_W:0]        next_code;
   logic                   stay_on_ch;
   logic                   cnt_load, cnt_dec, cnt_zero;
   logic [DWELL_W-1:0]     cnt_val;

   // A dwell of zero settles for one cycle, so the counter is loaded with dwell-1 floored at 0.
   function automatic logic [DWELL_W-1:0] dwell_m1(input logic [DWELL_W-1:0] d);
      return (d == '0) ? '0 : d - 1'b1;
   endfunction

   always_comb begin
      first_found  = 1'b0;
      higher_found = 1'b0;
      wrap_found   = 1'b0;
      idle_like    = (state_q == StIdle) || (state_q == StDone);
      first_idx    = CH_W'(next_set_bit(MAX_CH'(ch_mask), -1, first_found));
      higher_idx   = CH_W'(next_set_bit(MAX_CH'(mask_q), int'(ch_q), higher_found));
      wrap_idx     = CH_W'(next_set_bit(MAX_CH'(mask_q), -1, wrap_found));
      step_eff     = (step_q == '0) ? CODE_W'(1) : step_q;
      // Extra bit catches wrap past the top code.
      next_code    = {1'b0, code_q} + {1'b0, step_eff};
      stay_on_ch   = !next_code[CODE_W] && (next_code[CODE_W-1:0] <= stop_q);
      cnt_load     = !abort && ((idle_like && start && first_found) || (state_q == StStep));
      cnt_dec      = !abort && (state_q == StSettle);
      cnt_val      = idle_like ? dwell_m1(dwell) : dwell_m1(dwell_q);
   end

   bias_dwell_cnt #(
      .W (DWELL_W)
   ) u_dwell_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (ena),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         mask_q  <= '0;
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         dwell_q <= '0;
         cont_q  <= 1'b0;
         code_q  <= '0;
         bias_q  <= {N_CH{PARK}};
         ch_q    <= '0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (ena) begin
         done_q <= 1'b0;
         if (abort) begin
            state_q <= StIdle;
            bias_q  <= {N_CH{PARK}};
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle, StDone: begin
                  if (start) begin
                     if (!first_found) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                     end else begin
                        mask_q  <= ch_mask;
                        start_q <= start_code;
                        stop_q  <= stop_code;
                        step_q  <= step_code;
                        dwell_q <= dwell;
                        cont_q  <= cont;
                        err_q   <= 1'b0;
                        ch_q    <= first_idx;
                        code_q  <= start_code;
                        bias_q[first_idx*CODE_W +: CODE_W] <= start_code;
                        busy_q  <= 1'b1;
                        state_q <= StSettle;
                     end
                  end
               end
               StSettle: begin
                  if (cnt_zero) begin
                     req_q   <= 1'b1;
                     state_q <= StSample;
                  end
               end
               StSample: begin
                  if (sample_ack) begin
                     req_q   <= 1'b0;
                     state_q <= StStep;
                  end
               end
               StStep: begin
                  if (stay_on_ch) begin
                     code_q  <= next_code[CODE_W-1:0];
                     bias_q[ch_q*CODE_W +: CODE_W] <= next_code[CODE_W-1:0];
                     state_q <= StSettle;
                  end else begin
                     // Park first; a later write to the same slice (wrap onto itself) wins.
                     bias_q[ch_q*CODE_W +: CODE_W] <= PARK;
                     if (higher_found) begin
                        ch_q    <= higher_idx;
                        code_q  <= start_q;
                        bias_q[higher_idx*CODE_W +: CODE_W] <= start_q;
                        state_q <= StSettle;
                     end else if (cont_q && wrap_found) begin
                        ch_q    <= wrap_idx;
                        code_q  <= start_q;
                        bias_q[wrap_idx*CODE_W +: CODE_W] <= start_q;
                        state_q <= StSettle;
                     end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bias_code  = bias_q;
   assign ch_idx     = ch_q;
   assign sample_req = req_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_bias_sweep_ctrl.sv
// Randomized bench for bias_sweep_ctrl: expected sweep points come from a list-based model
// of the start/stop/step rules, checked at every sample request.
module tb_bias_sweep_ctrl;

   localparam int CODE_W  = 4;
   localparam int N_CH    = 2;
   localparam int DWELL_W = 8;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   ena, start, abort, cont, sample_ack;
   logic [N_CH-1:0]        ch_mask;
   logic [CODE_W-1:0]      start_code, stop_code, step_code;
   logic [DWELL_W-1:0]     dwell;
   logic [N_CH*CODE_W-1:0] bias_code;
   logic [0:0]             ch_idx;
   logic                   sample_req, busy, done, err;

   int total = 0;
   int bad   = 0;
   int mon_viol;

   bias_sweep_ctrl #(
      .CODE_W    (CODE_W),
      .N_CH      (N_CH),
      .DWELL_W   (DWELL_W),
      .PARK_CODE (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .start      (start),
      .abort      (abort),
      .cont       (cont),
      .ch_mask    (ch_mask),
      .start_code (start_code),
      .stop_code  (stop_code),
      .step_code  (step_code),
      .dwell      (dwell),
      .sample_ack (sample_ack),
      .bias_code  (bias_code),
      .ch_idx     (ch_idx),
      .sample_req (sample_req),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   // Any slice other than the one being swept must sit at the park code.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < N_CH; k++) begin
            if (!(busy && (k == int'(ch_idx))) && (bias_code[k*CODE_W +: CODE_W] != 4'd1))
               mon_viol++;
         end
      end
   end

   // Called at a negedge; builds the expected point list and walks the handshake.
   task automatic run_sweep(input logic [1:0] m, input logic [3:0] s, input logic [3:0] e,
                            input logic [3:0] st, input logic [7:0] dw, input bit c,
                            input int npts, input bit do_abort);
      int         pch[$];
      int         pcode[$];
      int         base, total_pts, dweff, stp, settle, lat, code;
      bit         seen;
      logic [7:0] expv;
      stp = (st == 0) ? 1 : int'(st);
      for (int ch = 0; ch < N_CH; ch++) begin
         if (m[ch]) begin
            code = int'(s);
            forever begin
               pch.push_back(ch);
               pcode.push_back(code);
               if ((code + stp <= int'(e)) && (code + stp <= 15)) code += stp;
               else break;
            end
         end
      end
      base      = pch.size();
      total_pts = c ? npts : base;
      dweff     = (dw == 0) ? 1 : int'(dw);
      mon_viol  = 0;
      ch_mask = m; start_code = s; stop_code = e; step_code = st; dwell = dw; cont = c;
      start = 1'b1;
      for (int p = 0; p < total_pts; p++) begin
         settle = 0;
         seen   = 1'b0;
         for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            start      = 1'b0;
            sample_ack = 1'b0;
            if (p == 0 && k == 0) check("err_clr", err, 0);
            if (sample_req) seen = 1'b1;
            else begin
               settle++;
               sample_ack = 1'($urandom % 2);
               if (p == 1 && k == 0) begin
                  start      = 1'b1;
                  ch_mask    = 2'($urandom);
                  start_code = 4'($urandom);
               end
            end
         end
         check("req_seen", seen, 1);
         if (!seen) return;
         check("settle", settle, (p == 0) ? dweff : dweff + 1);
         check("ch_idx", ch_idx, pch[p % base]);
         expv = 8'h11;
         expv[pch[p % base]*CODE_W +: CODE_W] = 4'(pcode[p % base]);
         check("code", bias_code, expv);
         if (do_abort && p == total_pts - 1) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_req", sample_req, 0);
            check("abort_park", bias_code, 8'h11);
            seen = 1'b0;
            repeat (4) begin
               @(negedge clk);
               if (done) seen = 1'b1;
            end
            check("abort_no_done", seen, 0);
            check("park_inactive", mon_viol, 0);
            return;
         end
         lat = $urandom_range(0, 3);
         if (lat > 0) begin
            repeat (lat) @(negedge clk);
            check("req_hold", sample_req, 1);
         end
         sample_ack = 1'b1;
      end
      settle = 0;
      seen   = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         sample_ack = 1'b0;
         settle++;
         if (done) seen = 1'b1;
      end
      check("done_lat", settle, 2);
      check("done_busy", busy, 0);
      check("done_park", bias_code, 8'h11);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("park_inactive", mon_viol, 0);
   endtask

   initial begin
      int         settle, frz_viol;
      bit         seen;
      logic [7:0] snap;
      rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0; sample_ack = 1'b0;
      ch_mask = '0; start_code = '0; stop_code = '0; step_code = '0; dwell = '0;
      mon_viol = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_code", bias_code, 8'h11);
      check("rst_ch", ch_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_req", sample_req, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);

      run_sweep(2'b01, 4'd2, 4'd8, 4'd3, 8'd4, 1'b0, 0, 1'b0);
      run_sweep(2'b01, 4'd14, 4'd15, 4'd0, 8'd2, 1'b0, 0, 1'b0);
      run_sweep(2'b01, 4'd13, 4'd15, 4'd4, 8'd1, 1'b0, 0, 1'b0);

      // Empty mask: error and done pulse, no sweep.
      ch_mask = 2'b00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("empty_done", done, 1);
      check("empty_err", err, 1);
      check("empty_busy", busy, 0);
      @(negedge clk);
      check("empty_done_pulse", done, 0);
      check("empty_err_sticky", err, 1);

      // Abort beats start.
      ch_mask = 2'b01; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("abort_start_busy", busy, 0);
      check("abort_start_err", err, 1);

      run_sweep(2'b11, 4'd3, 4'd4, 4'd1, 8'd2, 1'b1, 6, 1'b1);

      // Clock-enable freeze during settle.
      ch_mask = 2'b01; start_code = 4'd5; stop_code = 4'd5; step_code = 4'd1;
      dwell = 8'd6; cont = 1'b0; start = 1'b1;
      settle = 0; frz_viol = 0;
      @(negedge clk);
      start = 1'b0; settle++;
      @(negedge clk);
      settle++;
      snap = bias_code;
      ena  = 1'b0;
      repeat (5) begin
         @(negedge clk);
         settle++;
         if (bias_code != snap || !busy || sample_req || done) frz_viol++;
      end
      ena  = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         if (sample_req) seen = 1'b1;
         else settle++;
      end
      check("frz_hold", frz_viol, 0);
      check("frz_settle", settle, 11);
      check("frz_code", bias_code, 8'h15);
      sample_ack = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         sample_ack = 1'b0;
         if (done) seen = 1'b1;
      end
      check("frz_done", seen, 1);

      // Asynchronous reset in the middle of settle on channel 1.
      ch_mask = 2'b10; start_code = 4'd9; stop_code = 4'd15; step_code = 4'd1;
      dwell = 8'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_code", bias_code, 8'h11);
      check("arst_busy", busy, 0);
      check("arst_req", sample_req, 0);
      check("arst_ch", ch_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_sweep(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
                   8'($urandom_range(0, 6)), 1'b0, 0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
